// File: rtl/cpu_sequencer_pkg.sv
// Shared types and phase constants for the CPU timing-phase sequencer.
package cpu_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        STEP   = 2'd2,
        HALTED = 2'd3
    } seq_state_t;

    localparam int PHASES = 16;
    localparam logic [3:0] PH_LAST      = 4'(PHASES - 1);
    localparam logic [3:0] PH_FETCH_END = 4'd7;
    localparam logic [3:0] PH_ALU       = 4'd12;

endpackage

// File: rtl/seq_phase_ctr.sv
// Four-bit instruction phase counter; forced to 0 whenever the sequencer is not busy.
module seq_phase_ctr
    import cpu_sequencer_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic [3:0] ph,
    output logic [3:0] ph_next,
    output logic       wrap
);

    // ph_next is exported so the top can register phase outputs aligned with ph.
    assign ph_next = en ? ph + 4'd1 : 4'd0;
    assign wrap    = en && (ph == PH_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ph <= 4'd0;
        end else begin
            ph <= ph_next;
        end
    end

endmodule

// File: rtl/cpu_sequencer.sv
// Run/step/halt sequencer producing the core's phase clocks and counting retired instructions.
module cpu_sequencer
    import cpu_sequencer_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             step,
    input  logic             clear,
    input  logic             halt,
    output logic             cntrl_clk,
    output logic             alu_clk,
    output logic             fetch,
    output logic             busy,
    output logic             halted,
    output logic             instr_done,
    output logic [CNT_W-1:0] instr_count
);

    seq_state_t state;
    seq_state_t state_next;
    logic       busy_now;
    logic       next_busy;
    logic       halt_q;
    logic       halt_seen;
    logic [3:0] ph;
    logic [3:0] ph_next;
    logic       wrap;

    assign busy_now  = (state == RUN) || (state == STEP);
    assign next_busy = (state_next == RUN) || (state_next == STEP);
    assign halt_seen = halt_q | halt;

    seq_phase_ctr u_phase (
        .clk     (clk),
        .rst     (rst),
        .en      (busy_now),
        .ph      (ph),
        .ph_next (ph_next),
        .wrap    (wrap)
    );

    // State changes out of RUN/STEP only happen on the instruction boundary.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (run) begin
                    state_next = RUN;
                end else if (step) begin
                    state_next = STEP;
                end
            end
            RUN: begin
                if (wrap) begin
                    if (halt_seen) begin
                        state_next = HALTED;
                    end else if (!run) begin
                        state_next = IDLE;
                    end
                end
            end
            STEP: begin
                if (wrap) begin
                    state_next = halt_seen ? HALTED : IDLE;
                end
            end
            HALTED: begin
                if (clear) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            halt_q <= 1'b0;
        end else if (clear || wrap) begin
            halt_q <= 1'b0;
        end else if (busy_now && halt) begin
            halt_q <= 1'b1;
        end
    end

    // Phase outputs are decoded from the next phase so they line up with ph.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cntrl_clk <= 1'b0;
            fetch     <= 1'b0;
            alu_clk   <= 1'b0;
        end else begin
            cntrl_clk <= next_busy && ph_next[0];
            fetch     <= next_busy && (ph_next <= PH_FETCH_END);
            alu_clk   <= next_busy && (ph_next == PH_ALU);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_done  <= 1'b0;
            instr_count <= '0;
        end else begin
            instr_done <= wrap;
            if (wrap && (instr_count != {CNT_W{1'b1}})) begin
                instr_count <= instr_count + CNT_W'(1);
            end
        end
    end

    assign busy   = busy_now;
    assign halted = (state == HALTED);

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench: cycle model of the run/step/halt rules plus directed literal checks.
module tb_cpu_sequencer;

    localparam int M_IDLE   = 0;
    localparam int M_RUN    = 1;
    localparam int M_STEP   = 2;
    localparam int M_HALTED = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic run = 1'b0;
    logic step = 1'b0;
    logic clear = 1'b0;
    logic halt = 1'b0;

    logic        cntrl_a, alu_a, fetch_a, busy_a, halted_a, done_a;
    logic [15:0] count_a;
    logic        cntrl_b, alu_b, fetch_b, busy_b, halted_b, done_b;
    logic [3:0]  count_b;

    int n_checks = 0;
    int n_fails  = 0;
    bit check_en = 1'b0;

    int m_mode = M_IDLE;
    int m_ph = 0;
    bit m_hreq = 1'b0;
    bit m_pending = 1'b0;
    int m_cnt = 0;
    int m_cnt_sat = 0;
    bit m_done = 1'b0;

    int st_busy, st_rise, st_fetch, st_alu, st_alu_idx, st_done;

    cpu_sequencer dut_a (
        .clk(clk), .rst(rst), .run(run), .step(step), .clear(clear), .halt(halt),
        .cntrl_clk(cntrl_a), .alu_clk(alu_a), .fetch(fetch_a), .busy(busy_a),
        .halted(halted_a), .instr_done(done_a), .instr_count(count_a)
    );

    cpu_sequencer #(.CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .run(run), .step(step), .clear(clear), .halt(halt),
        .cntrl_clk(cntrl_b), .alu_clk(alu_b), .fetch(fetch_b), .busy(busy_b),
        .halted(halted_b), .instr_done(done_b), .instr_count(count_b)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic r, input logic s, input logic c, input logic h, input int cycles);
        run   = r;
        step  = s;
        clear = c;
        halt  = h;
        waitCycles(cycles);
    endtask

    // Behaviour of one instruction: 16 phases, decisions only at the last phase.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode = M_IDLE;
            m_ph = 0;
            m_hreq = 1'b0;
            m_cnt = 0;
            m_cnt_sat = 0;
            m_done = 1'b0;
        end else begin
            m_done = 1'b0;
            case (m_mode)
                M_IDLE: begin
                    if (run) m_mode = M_RUN;
                    else if (step) m_mode = M_STEP;
                end
                M_RUN, M_STEP: begin
                    m_pending = m_hreq || halt;
                    if (m_ph == 15) begin
                        m_done = 1'b1;
                        m_cnt = (m_cnt < 65535) ? m_cnt + 1 : m_cnt;
                        m_cnt_sat = (m_cnt_sat < 15) ? m_cnt_sat + 1 : m_cnt_sat;
                        m_ph = 0;
                        m_hreq = 1'b0;
                        if (m_pending) m_mode = M_HALTED;
                        else if (m_mode == M_STEP || !run) m_mode = M_IDLE;
                    end else begin
                        m_ph = m_ph + 1;
                        m_hreq = m_pending && !clear;
                    end
                end
                default: begin
                    if (clear) m_mode = M_IDLE;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (!rst && check_en) begin
            bit e_busy;
            e_busy = (m_mode == M_RUN) || (m_mode == M_STEP);
            checkOutput("a.busy", 32'(busy_a), 32'(e_busy));
            checkOutput("a.halted", 32'(halted_a), 32'(m_mode == M_HALTED));
            checkOutput("a.cntrl_clk", 32'(cntrl_a), 32'(e_busy && (m_ph % 2 == 1)));
            checkOutput("a.fetch", 32'(fetch_a), 32'(e_busy && (m_ph < 8)));
            checkOutput("a.alu_clk", 32'(alu_a), 32'(e_busy && (m_ph == 12)));
            checkOutput("a.instr_done", 32'(done_a), 32'(m_done));
            checkOutput("a.instr_count", 32'(count_a), m_cnt);
            checkOutput("b.busy", 32'(busy_b), 32'(e_busy));
            checkOutput("b.halted", 32'(halted_b), 32'(m_mode == M_HALTED));
            checkOutput("b.cntrl_clk", 32'(cntrl_b), 32'(e_busy && (m_ph % 2 == 1)));
            checkOutput("b.fetch", 32'(fetch_b), 32'(e_busy && (m_ph < 8)));
            checkOutput("b.alu_clk", 32'(alu_b), 32'(e_busy && (m_ph == 12)));
            checkOutput("b.instr_done", 32'(done_b), 32'(m_done));
            checkOutput("b.instr_count", 32'(count_b), m_cnt_sat);
        end
    end

    task automatic observeWindow(input int n);
        logic prev_cntrl;
        prev_cntrl = 1'b0;
        st_busy = 0; st_rise = 0; st_fetch = 0; st_alu = 0; st_alu_idx = -1; st_done = 0;
        repeat (n) begin
            @(negedge clk);
            if (cntrl_a && !prev_cntrl) st_rise++;
            prev_cntrl = cntrl_a;
            if (fetch_a) st_fetch++;
            if (done_a) st_done++;
            if (busy_a) begin
                if (alu_a) begin
                    st_alu++;
                    st_alu_idx = st_busy;
                end
                st_busy++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic stepAndObserve(input string tag);
        applyStimulus(0, 1, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0);
        observeWindow(24);
        checkOutput({tag, ".busy_cycles"}, st_busy, 16);
        checkOutput({tag, ".cntrl_rises"}, st_rise, 8);
        checkOutput({tag, ".fetch_cycles"}, st_fetch, 8);
        checkOutput({tag, ".alu_pulses"}, st_alu, 1);
        checkOutput({tag, ".alu_phase"}, st_alu_idx, 12);
        checkOutput({tag, ".done_pulses"}, st_done, 1);
        checkOutput({tag, ".busy_after"}, 32'(busy_a), 0);
    endtask

    initial begin
        $display("[TB] start");
        waitCycles(3);
        rst = 1'b0;
        check_en = 1'b1;
        waitCycles(20);
        checkOutput("reset.busy", 32'(busy_a), 0);
        checkOutput("reset.fetch", 32'(fetch_a), 0);
        checkOutput("reset.cntrl_clk", 32'(cntrl_a), 0);
        checkOutput("reset.count", 32'(count_a), 0);

        stepAndObserve("step1");
        checkOutput("step1.count", 32'(count_a), 1);

        // run held for 40 sampled edges: third instruction finishes, no partial fourth
        applyStimulus(1, 0, 0, 0, 40);
        applyStimulus(0, 0, 0, 0, 12);
        checkOutput("freerun.count", 32'(count_a), 4);
        checkOutput("freerun.busy", 32'(busy_a), 0);

        // halt pulse at phase 5 of a running instruction
        applyStimulus(1, 0, 0, 0, 6);
        applyStimulus(1, 0, 0, 1, 1);
        applyStimulus(1, 0, 0, 0, 12);
        checkOutput("halt.halted", 32'(halted_a), 1);
        checkOutput("halt.busy", 32'(busy_a), 0);
        checkOutput("halt.fetch", 32'(fetch_a), 0);
        checkOutput("halt.count", 32'(count_a), 5);
        applyStimulus(1, 1, 0, 0, 1);
        applyStimulus(1, 0, 0, 0, 5);
        checkOutput("halt.ignore_halted", 32'(halted_a), 1);
        checkOutput("halt.ignore_count", 32'(count_a), 5);
        applyStimulus(1, 0, 1, 0, 1);
        checkOutput("clear.halted", 32'(halted_a), 0);
        checkOutput("clear.busy", 32'(busy_a), 0);
        applyStimulus(1, 0, 0, 0, 1);
        checkOutput("clear.run_busy", 32'(busy_a), 1);
        checkOutput("clear.run_fetch", 32'(fetch_a), 1);
        applyStimulus(0, 0, 0, 0, 20);
        checkOutput("clear.count", 32'(count_a), 6);
        checkOutput("clear.idle", 32'(busy_a), 0);

        // twenty instructions back to back
        applyStimulus(1, 0, 0, 0, 311);
        applyStimulus(0, 0, 0, 0, 20);
        checkOutput("sat.count_w4", 32'(count_b), 15);
        checkOutput("sat.count_w16", 32'(count_a), 26);

        // asynchronous reset at phase 9
        applyStimulus(1, 0, 0, 0, 10);
        checkOutput("async.pre_cntrl", 32'(cntrl_a), 1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async.busy", 32'(busy_a), 0);
        checkOutput("async.cntrl_clk", 32'(cntrl_a), 0);
        checkOutput("async.fetch", 32'(fetch_a), 0);
        checkOutput("async.count_a", 32'(count_a), 0);
        checkOutput("async.count_b", 32'(count_b), 0);
        run = 1'b0;
        waitCycles(2);
        rst = 1'b0;
        waitCycles(2);
        stepAndObserve("step2");
        checkOutput("step2.count", 32'(count_a), 1);
        checkOutput("step2.count_b", 32'(count_b), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
